// File: rtl/bnn_seq_pkg.sv
// Shared definitions for the sequential BNN front-end stages:
// sequencer state encoding and the default compute-hold length.
package bnn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int HOLD_CYCLES_DEF = 46;

endpackage

// File: rtl/bnn_feature_sequencer_if.sv
// Feature-stream input and prediction-result output handshakes of the
// BNN feature sequencer.
interface bnn_feature_sequencer_if #(
  parameter int FEAT_BITS = 4,
  parameter int PRED_W    = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FEAT_BITS-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ack;
  logic [PRED_W-1:0]    result;

  modport slave (
    input  in_valid, in_data, in_last, out_ack,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, in_data, in_last, out_ack,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/feature_shadow_buf.sv
// Assembles one frame of features from a word stream into a shadow register,
// flags framing errors and holds the frame until the sequencer commits it.
module feature_shadow_buf #(
  parameter int FEAT_CNT  = 11,
  parameter int FEAT_BITS = 4,
  localparam int FEAT_W   = FEAT_CNT * FEAT_BITS,
  localparam int IDX_W    = $clog2(FEAT_CNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [FEAT_BITS-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 commit,
  output logic [FEAT_W-1:0]    shadow,
  output logic                 shadow_full,
  output logic                 err_len
);

  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [FEAT_W-1:0] shadow_q, shadow_d;
  logic              full_q,   full_d;
  logic              err_q,    err_d;
  logic              accept;

  assign in_ready    = !full_q;
  assign accept      = in_valid && in_ready;
  assign shadow      = shadow_q;
  assign shadow_full = full_q;
  assign err_len     = err_q;

  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    err_d    = 1'b0;
    if (commit) begin
      full_d = 1'b0;
    end
    if (accept) begin
      for (int k = 0; k < FEAT_CNT; k++) begin
        if (idx_q == IDX_W'(k)) begin
          shadow_d[k*FEAT_BITS +: FEAT_BITS] = in_data;
        end
      end
      // A full frame is kept even without in_last; an early in_last drops it.
      if (idx_q == IDX_W'(FEAT_CNT - 1)) begin
        full_d = 1'b1;
        idx_d  = {IDX_W{1'b0}};
        err_d  = !in_last;
      end else if (in_last) begin
        idx_d  = {IDX_W{1'b0}};
        err_d  = 1'b1;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= {IDX_W{1'b0}};
      shadow_q <= {FEAT_W{1'b0}};
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: rtl/bnn_feature_sequencer.sv
// Front end for the sequential BNN: commits assembled frames to a stable
// feature vector, pulses the BNN reset, waits for compute and reports the result.
module bnn_feature_sequencer
  import bnn_seq_pkg::*;
#(
  parameter int FEAT_CNT    = 11,
  parameter int FEAT_BITS   = 4,
  parameter int CLASS_CNT   = 6,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int PRED_W     = $clog2(CLASS_CNT),
  localparam int FEAT_W     = FEAT_CNT * FEAT_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  bnn_feature_sequencer_if.slave bus,
  output logic [FEAT_W-1:0]     features,
  output logic                  bnn_rst,
  input  logic [PRED_W-1:0]     pred_in,
  output logic                  err_len
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  seq_state_e        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [FEAT_W-1:0] features_q, features_d;
  logic [PRED_W-1:0] result_q,   result_d;
  logic [FEAT_W-1:0] shadow;
  logic              shadow_full;
  logic              commit;

  feature_shadow_buf #(
    .FEAT_CNT  (FEAT_CNT),
    .FEAT_BITS (FEAT_BITS)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (bus.in_valid),
    .in_data     (bus.in_data),
    .in_last     (bus.in_last),
    .in_ready    (bus.in_ready),
    .commit      (commit),
    .shadow      (shadow),
    .shadow_full (shadow_full),
    .err_len     (err_len)
  );

  assign commit = shadow_full &&
                  ((state_q == IDLE) || ((state_q == DONE) && bus.out_ack));

  assign features      = features_q;
  assign bus.result    = result_q;
  assign bus.out_valid = (state_q == DONE);
  assign bnn_rst       = (state_q == IDLE) || (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    features_d = features_q;
    result_d   = result_q;
    if (commit) begin
      features_d = shadow;
    end
    case (state_q)
      IDLE: begin
        if (commit) state_d = LOAD;
        else        state_d = IDLE;
      end
      LOAD: begin
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        state_d = RUN;
      end
      RUN: begin
        // Prediction is sampled on the last of HOLD_CYCLES compute cycles.
        if (cnt_q == {CNT_W{1'b0}}) begin
          result_d = pred_in;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ack) state_d = shadow_full ? LOAD : IDLE;
        else             state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      features_q <= {FEAT_W{1'b0}};
      result_q   <= {PRED_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      features_q <= features_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_bnn_feature_sequencer.sv
// Directed bench for bnn_feature_sequencer: table-driven frames plus
// hand-written sequences for framing errors, back-to-back frames and reset.
module tb_bnn_feature_sequencer;

  logic        clk;
  logic        rst;
  logic [43:0] features;
  logic        bnn_rst;
  logic [2:0]  pred_in;
  logic        err_len;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  bnn_feature_sequencer_if #(.FEAT_BITS(4), .PRED_W(3)) bus ();

  bnn_feature_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .features (features),
    .bnn_rst  (bnn_rst),
    .pred_in  (pred_in),
    .err_len  (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_len === 1'b1) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [43:0] words;
    int          last_pos;
    logic [43:0] exp_feat;
    int          exp_err;
    logic [2:0]  pred;
  } vec_t;

  vec_t vecs [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send n words (word k = w[4k+:4]); in_last on word last_pos.
  task automatic send_words(input logic [43:0] w, input int n, input int last_pos);
    for (int k = 0; k < n; k++) begin
      int to = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w[k*4 +: 4];
      bus.in_last  = (k == last_pos);
      while (bus.in_ready !== 1'b1 && to < 200) begin
        tick();
        to++;
      end
      if (to >= 200) check("accept_timeout", 64'd1, 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 4'd0;
  endtask

  // Entered in cycle 1 (LOAD); returns in cycle 48 (first DONE cycle).
  task automatic run_compute(input logic [43:0] exp_feat, input logic [2:0] pred, input string tag);
    int bad = 0;
    check({tag, "_load_feat"},   features,      exp_feat);
    check({tag, "_load_bnnrst"}, bnn_rst,       1'b1);
    check({tag, "_load_oval"},   bus.out_valid, 1'b0);
    check({tag, "_load_ready"},  bus.in_ready,  1'b1);
    for (int cyc = 1; cyc <= 47; cyc++) begin
      pred_in = (cyc == 47) ? pred : ~pred;
      if (cyc >= 2 && (bnn_rst !== 1'b0 || bus.out_valid !== 1'b0 || features !== exp_feat)) bad++;
      tick();
    end
    check({tag, "_run_bad"},    bad,           0);
    check({tag, "_done_oval"},  bus.out_valid, 1'b1);
    check({tag, "_done_res"},   bus.result,    pred);
    check({tag, "_done_feat"},  features,      exp_feat);
    check({tag, "_done_bnnrst"}, bnn_rst,      1'b0);
  endtask

  initial begin
    int e0;
    int bad;
    vecs[0] = '{44'h321_0000_0000 ^ 44'h321_0000_0000 ^ 44'hBA987654321, 10, 44'hBA987654321, 0, 3'd5};
    vecs[1] = '{44'hFFFFFFFFFFF, 10, 44'hFFFFFFFFFFF, 0, 3'd2};
    vecs[2] = '{44'hA5A5A5A5A5A, 15, 44'hA5A5A5A5A5A, 1, 3'd0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 4'd0; bus.in_last = 1'b0; bus.out_ack = 1'b0;
    pred_in = 3'd0;
    tick(); tick();
    check("rst_ready",  bus.in_ready,  1'b1);
    check("rst_feat",   features,      44'd0);
    check("rst_bnnrst", bnn_rst,       1'b1);
    check("rst_oval",   bus.out_valid, 1'b0);
    check("rst_res",    bus.result,    3'd0);
    check("rst_err",    err_len,       1'b0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      e0 = err_cnt;
      send_words(vecs[v].words, 11, vecs[v].last_pos);
      check($sformatf("v%0d_ready_drop", v), bus.in_ready, 1'b0);
      tick();
      run_compute(vecs[v].exp_feat, vecs[v].pred, $sformatf("v%0d", v));
      check($sformatf("v%0d_err_cnt", v), err_cnt - e0, vecs[v].exp_err);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
      check($sformatf("v%0d_ack_oval", v), bus.out_valid, 1'b0);
      check($sformatf("v%0d_ack_idle", v), bnn_rst, 1'b1);
    end

    // Short frame: in_last on word 5 is dropped with one err_len pulse.
    e0 = err_cnt;
    send_words(44'h00000077777, 5, 4);
    repeat (3) tick();
    check("short_err_cnt", err_cnt - e0, 1);
    check("short_feat",    features,     44'hA5A5A5A5A5A);
    check("short_bnnrst",  bnn_rst,      1'b1);
    check("short_ready",   bus.in_ready, 1'b1);
    e0 = err_cnt;
    send_words(44'h13579BDF024, 11, 10);
    tick();
    run_compute(44'h13579BDF024, 3'd3, "after_short");
    check("after_short_err", err_cnt - e0, 0);
    bus.out_ack = 1'b1; tick(); bus.out_ack = 1'b0;

    // Frame A, frame B assembled during A's RUN, ack held off 20 cycles.
    send_words(44'h0F1E2D3C4B5, 11, 10);
    tick();
    fork
      run_compute(44'h0F1E2D3C4B5, 3'd1, "a");
      begin
        repeat (3) tick();
        send_words(44'h89ABCDEF012, 11, 10);
        check("b_ready_drop", bus.in_ready, 1'b0);
      end
    join
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.result !== 3'd1 || features !== 44'h0F1E2D3C4B5 ||
          bnn_rst !== 1'b0 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    check("hold_stable_bad", bad, 0);
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    fork
      run_compute(44'h89ABCDEF012, 3'd6, "b");
      begin
        repeat (3) tick();
        send_words(44'h55443322110, 11, 10);
      end
    join
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    run_compute(44'h55443322110, 3'd4, "c");
    bus.out_ack = 1'b1; tick(); bus.out_ack = 1'b0;
    check("c_idle_oval",   bus.out_valid, 1'b0);
    check("c_idle_bnnrst", bnn_rst,       1'b1);
    check("c_idle_res",    bus.result,    3'd4);

    // Reset during RUN with a half-filled shadow.
    send_words(44'h2468ACE1357, 11, 10);
    tick();
    send_words(44'h00000099999, 5, 15);
    repeat (4) tick();
    check("pre_rst_run", bnn_rst, 1'b0);
    e0 = err_cnt;
    rst = 1'b1;
    tick();
    check("mid_rst_feat",   features,      44'd0);
    check("mid_rst_bnnrst", bnn_rst,       1'b1);
    check("mid_rst_oval",   bus.out_valid, 1'b0);
    check("mid_rst_res",    bus.result,    3'd0);
    check("mid_rst_err",    err_len,       1'b0);
    check("mid_rst_ready",  bus.in_ready,  1'b1);
    rst = 1'b0;
    tick();
    send_words(44'h0FEDCBA9876, 11, 10);
    tick();
    run_compute(44'h0FEDCBA9876, 3'd5, "post_rst");
    check("post_rst_err", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
